// File: rtl/bsg_link_pkg.sv
// bsg_link_pkg
//   Shared sizing for the down-link controller. It holds the default FIFO
//   depth, the number of io beats per core word, and the number of pops per
//   returned token. It also holds the derived address and pointer widths and
//   the pointer type.
//   Ports: none (package).
package bsg_link_pkg;

   localparam int DEPTH       = 16;  // FIFO word entries, power of 2
   localparam int BEATS       = 4;   // 8-bit io beats per 32-bit core word
   localparam int TOKEN_DECIM = 4;   // core pops per returned token

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;  // extra MSB is the wrap bit

   typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/bsg_down_token_ctrl.sv
// bsg_down_token_ctrl
//   Counts core pops and returns one credit token upstream for every
//   TOKEN_DECIM pops. The token is a registered, one-cycle pulse. It is high
//   in the cycle after the pop that wraps the counter.
//   Ports:
//     clk          in   clock
//     rst          in   async active-high reset; clears the partial pop count
//     pop          in   a head word was consumed this cycle
//     io_token_out out  one-cycle credit-return pulse
module bsg_down_token_ctrl
   import bsg_link_pkg::*;
#(
   parameter int TOKEN_DECIM = bsg_link_pkg::TOKEN_DECIM
) (
   input  logic clk,
   input  logic rst,
   input  logic pop,
   output logic io_token_out
);

   localparam int CW = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;
   localparam logic [CW-1:0] LAST = CW'(TOKEN_DECIM - 1);

   logic [CW-1:0] tcnt;
   logic          wrap;

   assign wrap = pop && (tcnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt         <= '0;
         io_token_out <= 1'b0;
      end else begin
         io_token_out <= wrap;
         if (pop) tcnt <= wrap ? '0 : tcnt + 1'b1;
      end
   end

endmodule

// File: rtl/bsg_down_link_ctrl.sv
// bsg_down_link_ctrl
//   Control path for a down-link. It packs BEATS io beats into a core word
//   and writes that word into a DEPTH-entry FIFO. The FIFO data storage is
//   outside this block; this block drives only its addresses and its write
//   enable. Consumed words are counted and returned upstream as tokens.
//
//   Handshake: the head word is offered while core_valid_out=1. A pop
//   happens in exactly the cycles where core_valid_out=1 and core_ready=1,
//   and raddr advances at the following edge. io_valid_in has no
//   back-pressure. A word that completes while the FIFO is full is dropped.
//
//   Optional feature: define BSG_DOWN_OVERFLOW_CHECK_EN to make overflow_err
//   a sticky flag that is set by dropped words. Without that macro,
//   overflow_err is tied to 0.
//
//   Ports:
//     clk, rst        clock, async active-high reset
//     io_valid_in     an io beat is present this cycle
//     core_ready      the consumer accepts the head word
//     beat_sel        byte lane that captures io_data_in
//     word_we         write the completed word at waddr
//     waddr, raddr    FIFO write / head addresses
//     core_valid_out  head word valid
//     io_token_out    credit-return pulse
//     full, empty     FIFO status
//     occupancy       number of words stored
//     overflow_err    sticky overflow flag (feature macro)
module bsg_down_link_ctrl
   import bsg_link_pkg::*;
#(
   parameter int DEPTH       = bsg_link_pkg::DEPTH,
   parameter int BEATS       = bsg_link_pkg::BEATS,
   parameter int TOKEN_DECIM = bsg_link_pkg::TOKEN_DECIM
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      io_valid_in,
   input  logic                      core_ready,
   output logic [$clog2(BEATS)-1:0]  beat_sel,
   output logic                      word_we,
   output logic [$clog2(DEPTH)-1:0]  waddr,
   output logic [$clog2(DEPTH)-1:0]  raddr,
   output logic                      core_valid_out,
   output logic                      io_token_out,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic                      overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   logic [BW-1:0] bcnt;
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          word_done;  // last beat of a word arrives this cycle
   logic          pop;

   assign word_done = io_valid_in && (bcnt == LAST_BEAT);

   // full uses the registered pointers only. A pop in the same cycle does
   // not make room for a word that completes in that cycle.
   assign empty          = (wptr == rptr);
   assign full           = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign occupancy      = wptr - rptr;
   assign core_valid_out = !empty;
   assign pop            = core_valid_out && core_ready;
   assign word_we        = word_done && !full && !rst;
   assign beat_sel       = bcnt;
   assign waddr          = wptr[AW-1:0];
   assign raddr          = rptr[AW-1:0];

   // The beat counter wraps after the last beat even when the word is
   // dropped, so the next word stays aligned to the io stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt <= '0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (io_valid_in) bcnt <= word_done ? '0 : bcnt + 1'b1;
         if (word_we)     wptr <= wptr + 1'b1;
         if (pop)         rptr <= rptr + 1'b1;
      end
   end

`ifdef BSG_DOWN_OVERFLOW_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    overflow_err <= 1'b0;
      else if (word_done && full) overflow_err <= 1'b1;
   end
`else
   assign overflow_err = 1'b0;
`endif

   bsg_down_token_ctrl #(
      .TOKEN_DECIM (TOKEN_DECIM)
   ) u_token (
      .clk          (clk),
      .rst          (rst),
      .pop          (pop),
      .io_token_out (io_token_out)
   );

endmodule

// File: tb/tb_bsg_down_link_ctrl.sv
// tb_bsg_down_link_ctrl
//   Directed bench for bsg_down_link_ctrl with default parameters
//   (DEPTH 16, BEATS 4, TOKEN_DECIM 4). Inputs change 1 ns after the rising
//   edge. Outputs are sampled 1 ns later.
module tb_bsg_down_link_ctrl;

`ifdef BSG_DOWN_OVERFLOW_CHECK_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       io_valid_in;
   logic       core_ready;
   logic [1:0] beat_sel;
   logic       word_we;
   logic [3:0] waddr;
   logic [3:0] raddr;
   logic       core_valid_out;
   logic       io_token_out;
   logic       full;
   logic       empty;
   logic [4:0] occupancy;
   logic       overflow_err;

   int checks = 0;
   int errors = 0;
   int tok_cnt;

   // clock / reset
   always #5 clk = ~clk;

   bsg_down_link_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .io_valid_in    (io_valid_in),
      .core_ready     (core_ready),
      .beat_sel       (beat_sel),
      .word_we        (word_we),
      .waddr          (waddr),
      .raddr          (raddr),
      .core_valid_out (core_valid_out),
      .io_token_out   (io_token_out),
      .full           (full),
      .empty          (empty),
      .occupancy      (occupancy),
      .overflow_err   (overflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; io_valid_in = 1'b0; core_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic fill(input int words);
      io_valid_in = 1'b1;
      repeat (words * 4) tick();
      io_valid_in = 1'b0;
   endtask

   task automatic drain(input int words);
      core_ready = 1'b1;
      repeat (words) tick();
      core_ready = 1'b0;
   endtask

   initial begin
      // reset, with beats offered during reset
      rst = 1'b1; io_valid_in = 1'b1; core_ready = 1'b1;
      tick(); tick();
      settle();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_cvo", core_valid_out, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_beat_sel", beat_sel, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_token", io_token_out, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_word_we", word_we, 0);
      do_reset();

      // one word of 4 beats
      io_valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("w1_beat_sel", beat_sel, i);
         chk("w1_word_we", word_we, (i == 3) ? 1 : 0);
         if (i == 3) chk("w1_waddr", waddr, 0);
         tick();
      end
      io_valid_in = 1'b0;
      settle();
      chk("w1_occ", occupancy, 1);
      chk("w1_cvo", core_valid_out, 1);
      chk("w1_waddr_next", waddr, 1);

      // fill until full, then overflow
      do_reset();
      fill(16);
      settle();
      chk("fill_full", full, 1);
      chk("fill_occ", occupancy, 16);
      chk("fill_waddr", waddr, 0);
      chk("fill_empty", empty, 0);
      io_valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("ovf_word_we", word_we, 0);
         tick();
      end
      io_valid_in = 1'b0;
      settle();
      chk("ovf_occ", occupancy, 16);
      chk("ovf_flag", overflow_err, OVF_ON);
      chk("ovf_beat_sel", beat_sel, 0);

      // drain 16 words with token returns
      tok_cnt = 0;
      core_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         settle();
         chk("drain_raddr", raddr, i);
         chk("drain_cvo", core_valid_out, 1);
         chk("drain_token", io_token_out, (i > 0 && i % 4 == 0) ? 1 : 0);
         if (io_token_out) tok_cnt++;
         tick();
      end
      core_ready = 1'b0;
      settle();
      chk("drain_empty", empty, 1);
      chk("drain_occ", occupancy, 0);
      chk("drain_token_last", io_token_out, 1);
      if (io_token_out) tok_cnt++;
      tick();
      chk("drain_token_off", io_token_out, 0);
      chk("drain_token_count", tok_cnt, 4);
      chk("drain_ovf_sticky", overflow_err, OVF_ON);

      // full, with a pop in the same cycle as a completing beat
      do_reset();
      chk("reset_clears_ovf", overflow_err, 0);
      fill(16);
      io_valid_in = 1'b1;
      tick(); tick(); tick();
      core_ready = 1'b1;
      settle();
      chk("fp_full", full, 1);
      chk("fp_word_we", word_we, 0);
      tick();
      io_valid_in = 1'b0; core_ready = 1'b0;
      settle();
      chk("fp_occ", occupancy, 15);
      chk("fp_raddr", raddr, 1);
      chk("fp_waddr", waddr, 0);
      chk("fp_ovf", overflow_err, OVF_ON);

      // simultaneous write and pop at occupancy 5
      do_reset();
      fill(5);
      settle();
      chk("sim_occ_before", occupancy, 5);
      io_valid_in = 1'b1;
      tick(); tick(); tick();
      core_ready = 1'b1;
      settle();
      chk("sim_word_we", word_we, 1);
      chk("sim_cvo", core_valid_out, 1);
      tick();
      io_valid_in = 1'b0; core_ready = 1'b0;
      settle();
      chk("sim_occ", occupancy, 5);
      chk("sim_waddr", waddr, 6);
      chk("sim_raddr", raddr, 1);

      // partial word discarded by reset, then pointer wrap
      do_reset();
      io_valid_in = 1'b1;
      tick(); tick();
      do_reset();
      settle();
      chk("pr_beat_sel", beat_sel, 0);
      io_valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("pr_word_we", word_we, (i == 3) ? 1 : 0);
         if (i == 3) chk("pr_waddr", waddr, 0);
         tick();
      end
      io_valid_in = 1'b0;
      fill(15);
      settle();
      chk("wrap1_full", full, 1);
      drain(16);
      settle();
      chk("wrap1_empty", empty, 1);
      chk("wrap1_raddr", raddr, 0);
      fill(16);
      settle();
      chk("wrap2_full", full, 1);
      chk("wrap2_occ", occupancy, 16);
      chk("wrap2_empty", empty, 0);
      drain(16);
      settle();
      chk("wrap2_empty_end", empty, 1);
      chk("wrap2_full_end", full, 0);
      chk("wrap2_occ_end", occupancy, 0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
